// File: rtl/bp_be_dcache_mock_mem.sv
// bp_be_dcache_mock_mem: single-outstanding CCE memory responder over a byte store with fixed latency.
// Define BP_MOCK_MEM_STALL_EN to add LFSR-driven accept stalls and latency jitter.
module bp_be_dcache_mock_mem #(
  parameter int paddr_width_p = 40,
  parameter int cce_block_width_p = 512,
  parameter int payload_width_p = 16,
  parameter int mem_cap_in_bytes_p = 4096,
  parameter logic [31:0] mem_offset_p = 32'h8000_0000,
  parameter int mem_latency_p = 4,
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + payload_width_p + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_ready_i,
  output logic                            err_o
);
  localparam int hdr_w = cce_mem_msg_width_lp - cce_block_width_p;
  localparam int blk_bytes = cce_block_width_p / 8;
  localparam int lg_cap = $clog2(mem_cap_in_bytes_p);
  localparam int cnt_w = mem_latency_p > 1 ? $clog2(mem_latency_p + 1) : 1;
  localparam int aw = paddr_width_p + 1;
  typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;
  state_e state;
  logic [cnt_w-1:0] cnt;
  logic [7:0] mem [mem_cap_in_bytes_p];
  logic [3:0] cmd_type;
  logic [paddr_width_p-1:0] cmd_addr;
  logic [2:0] cmd_size;
  logic [cce_block_width_p-1:0] cmd_data, rd_data, resp_data;
  logic [7:0] bytes;
  logic [aw-1:0] off, idx;
  logic below, oor, known, is_wr, accept_ok, hold;
  // message layout, MSB first: {msg_type, addr, size, payload, data}
  assign cmd_type = mem_cmd_i[cce_mem_msg_width_lp-1 -: 4];
  assign cmd_addr = mem_cmd_i[cce_mem_msg_width_lp-5 -: paddr_width_p];
  assign cmd_size = mem_cmd_i[cce_block_width_p+payload_width_p +: 3];
  assign cmd_data = mem_cmd_i[cce_block_width_p-1:0];
  assign bytes = 8'(1) << cmd_size;
  assign below = cmd_addr < paddr_width_p'(mem_offset_p);
  assign off = {1'b0, cmd_addr} - aw'(mem_offset_p);
  assign idx = off & ~aw'(bytes - 8'(1));
  assign oor = below | (idx + aw'(bytes) > aw'(mem_cap_in_bytes_p));
  assign known = ~|cmd_type[3:2];
  assign is_wr = known & cmd_type[0];
  assign resp_data = (oor | ~known | is_wr) ? '0 : rd_data;
  assign mem_cmd_yumi_o = mem_cmd_v_i & (state == e_idle) & accept_ok;
`ifdef BP_MOCK_MEM_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) lfsr <= 8'h5A;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign accept_ok = ~lfsr[0];
  assign hold = lfsr[1];
`else
  assign accept_ok = 1'b1;
  assign hold = 1'b0;
`endif
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < blk_bytes; i++)
      rd_data[8*i +: 8] = (i < int'(bytes)) ? mem[lg_cap'(idx) + lg_cap'(i)] : 8'h00;
  end
  // store has no reset: committed writes survive a reset
  always_ff @(posedge clk_i)
    if (mem_cmd_yumi_o & is_wr & ~oor)
      for (int i = 0; i < blk_bytes; i++)
        if (i < int'(bytes)) mem[lg_cap'(idx) + lg_cap'(i)] <= cmd_data[8*i +: 8];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= e_idle;
      cnt <= '0;
      mem_resp_o <= '0;
      mem_resp_v_o <= 1'b0;
      err_o <= 1'b0;
    end else
      case (state)
        e_idle:
          if (mem_cmd_yumi_o) begin
            mem_resp_o <= {mem_cmd_i[cce_mem_msg_width_lp-1 -: hdr_w], resp_data};
            err_o <= err_o | oor | ~known;
            cnt <= cnt_w'(mem_latency_p);
            state <= (mem_latency_p == 0) ? e_resp : e_wait;
            mem_resp_v_o <= (mem_latency_p == 0);
          end
        e_wait:
          if (~hold) begin
            cnt <= cnt - cnt_w'(1);
            state <= (cnt == cnt_w'(1)) ? e_resp : e_wait;
            mem_resp_v_o <= (cnt == cnt_w'(1));
          end
        e_resp:
          if (mem_resp_ready_i) begin
            state <= e_idle;
            mem_resp_v_o <= 1'b0;
          end
        default: state <= e_idle;
      endcase
endmodule

// File: tb/tb_bp_be_dcache_mock_mem.sv
// tb_bp_be_dcache_mock_mem: directed checks of the mock memory (latency 4 main DUT, latency 0 side DUT).
module tb_bp_be_dcache_mock_mem;
  localparam int W = 4 + 40 + 3 + 16 + 512;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] cmd = '0, resp, resp0;
  logic cmd_v = 1'b0, cmd0_v = 1'b0, ready = 1'b1;
  logic yumi, resp_v, err, yumi0, resp0_v, err0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bp_be_dcache_mock_mem dut (
    .clk_i(clk), .reset_i(rst), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v), .mem_cmd_yumi_o(yumi),
    .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_ready_i(ready), .err_o(err));
  bp_be_dcache_mock_mem #(.mem_latency_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd0_v), .mem_cmd_yumi_o(yumi0),
    .mem_resp_o(resp0), .mem_resp_v_o(resp0_v), .mem_resp_ready_i(ready), .err_o(err0));
  function automatic logic [W-1:0] mk(logic [3:0] t, logic [39:0] a, logic [2:0] s, logic [511:0] d);
    return {t, a, s, 16'hBEEF, d};
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input string tag, input logic [W-1:0] m, input logic [W-1:0] exp);
    int n;
    @(negedge clk);
    cmd = m;
    cmd_v = 1'b1;
    #1 chk({tag, " yumi"}, W'(yumi), W'(1));
    @(posedge clk);
    #1 cmd_v = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_v && n < 40);
    chk({tag, " lat"}, W'(n), W'(5));
    chk({tag, " resp"}, resp, exp);
  endtask
  initial begin
    logic [511:0] blk;
    int n;
    for (int i = 0; i < 64; i++) blk[8*i +: 8] = 8'(i * 17);
    repeat (3) @(negedge clk);
    chk("rst resp_v", W'(resp_v), W'(0));
    chk("rst resp", resp, '0);
    chk("rst err", W'(err), W'(0));
    chk("rst yumi", W'(yumi), W'(0));
    rst = 1'b0;
    @(negedge clk);
    cmd = mk(4'd1, 40'h80000100, 3'd3, 512'h1234);
    cmd0_v = 1'b1;
    #1 chk("lat0 yumi", W'(yumi0), W'(1));
    @(posedge clk);
    #1 cmd0_v = 1'b0;
    @(negedge clk);
    chk("lat0 resp_v", W'(resp0_v), W'(1));
    chk("lat0 resp", resp0, mk(4'd1, 40'h80000100, 3'd3, '0));
    chk("lat0 err", W'(err0), W'(0));
    @(negedge clk);
    cmd = mk(4'd7, 40'h80000100, 3'd3, '0);
    cmd0_v = 1'b1;
    @(posedge clk);
    #1 cmd0_v = 1'b0;
    @(negedge clk);
    chk("unk resp", resp0, mk(4'd7, 40'h80000100, 3'd3, '0));
    chk("unk err", W'(err0), W'(1));
    xact("blk wr", mk(4'd1, 40'h80000040, 3'd6, blk), mk(4'd1, 40'h80000040, 3'd6, '0));
    chk("blk wr err", W'(err), W'(0));
    xact("blk rd", mk(4'd0, 40'h80000040, 3'd6, '0), mk(4'd0, 40'h80000040, 3'd6, blk));
    xact("uc wr8", mk(4'd3, 40'h80000000, 3'd3, 512'h0706050403020100),
         mk(4'd3, 40'h80000000, 3'd3, '0));
    xact("uc wr1", mk(4'd3, 40'h80000003, 3'd0, 512'hCDCDCDCDCDCDCDAB),
         mk(4'd3, 40'h80000003, 3'd0, '0));
    xact("uc rd8", mk(4'd2, 40'h80000000, 3'd3, '0),
         mk(4'd2, 40'h80000000, 3'd3, 512'h07060504AB020100));
    xact("uc rd4 align", mk(4'd2, 40'h80000006, 3'd2, '0),
         mk(4'd2, 40'h80000006, 3'd2, 512'h07060504));
    xact("top wr", mk(4'd3, 40'h80000FF8, 3'd3, 512'hDEADBEEF0BADF00D),
         mk(4'd3, 40'h80000FF8, 3'd3, '0));
    xact("top rd", mk(4'd2, 40'h80000FF8, 3'd3, '0),
         mk(4'd2, 40'h80000FF8, 3'd3, 512'hDEADBEEF0BADF00D));
    chk("top err", W'(err), W'(0));
    @(negedge clk);
    cmd = mk(4'd2, 40'h80000040, 3'd3, '0);
    cmd_v = 1'b1;
    ready = 1'b0;
    #1 chk("bp yumi1", W'(yumi), W'(1));
    @(posedge clk);
    #1 cmd = mk(4'd2, 40'h80000000, 3'd3, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      chk("bp yumi busy", W'(yumi), W'(0));
    end while (!resp_v && n < 40);
    chk("bp lat", W'(n), W'(5));
    chk("bp resp", resp, mk(4'd2, 40'h80000040, 3'd3, 512'h7766554433221100));
    repeat (4) begin
      @(negedge clk);
      chk("bp hold resp", resp, mk(4'd2, 40'h80000040, 3'd3, 512'h7766554433221100));
      chk("bp hold v", W'(resp_v), W'(1));
      chk("bp hold yumi", W'(yumi), W'(0));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp post v", W'(resp_v), W'(0));
    chk("bp post yumi", W'(yumi), W'(1));
    @(posedge clk);
    #1 cmd_v = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_v && n < 40);
    chk("bp2 lat", W'(n), W'(5));
    chk("bp2 resp", resp, mk(4'd2, 40'h80000000, 3'd3, 512'h07060504AB020100));
    xact("oor rd", mk(4'd2, 40'h80001000, 3'd3, '0), mk(4'd2, 40'h80001000, 3'd3, '0));
    chk("oor err", W'(err), W'(1));
    xact("oor wr hi", mk(4'd3, 40'h80001000, 3'd3, 512'h5555555555555555),
         mk(4'd3, 40'h80001000, 3'd3, '0));
    xact("oor wr lo", mk(4'd3, 40'h7FFFFFF8, 3'd3, 512'h6666666666666666),
         mk(4'd3, 40'h7FFFFFF8, 3'd3, '0));
    xact("after oor rd0", mk(4'd2, 40'h80000000, 3'd3, '0),
         mk(4'd2, 40'h80000000, 3'd3, 512'h07060504AB020100));
    xact("after oor rdtop", mk(4'd2, 40'h80000FF8, 3'd3, '0),
         mk(4'd2, 40'h80000FF8, 3'd3, 512'hDEADBEEF0BADF00D));
    chk("err sticky", W'(err), W'(1));
    @(negedge clk);
    cmd = mk(4'd0, 40'h80000040, 3'd6, '0);
    cmd_v = 1'b1;
    @(posedge clk);
    #1 cmd_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid rst v", W'(resp_v), W'(0));
    chk("mid rst err", W'(err), W'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no resp after rst", W'(resp_v), W'(0));
    end
    xact("post rst rd", mk(4'd0, 40'h80000040, 3'd6, '0), mk(4'd0, 40'h80000040, 3'd6, blk));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
